// File: rtl/csi_axis_out.sv
// rtl/csi_axis_out.sv - stereo parallel video to 32-bit AXI4-Stream bridge with SOF/EOL framing
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   enb                block enable; low synchronously flushes FIFO and clears state/flags
//   sof_in             one-cycle frame-start pulse
//   v_in               pixel valid (cannot be stalled)
//   d1_in, d2_in       channel-1 / channel-2 pixel words
//   m_axis_t*          AXI4-Stream master: tdata={d2,d1}, tuser=SOF, tlast=EOL
//   fifo_cnt           words held (including the one presented on m_axis)
//   frame_cnt          completed frames, wraps
//   ovf                sticky: pixel dropped on full FIFO
//   len_err            sticky: sof_in arrived mid-frame
module csi_axis_out #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enb,
    input  logic               sof_in,
    input  logic               v_in,
    input  logic [15:0]        d1_in,
    input  logic [15:0]        d2_in,
    output logic [31:0]        m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tuser,
    output logic               m_axis_tlast,
    output logic [FIFO_AW:0]   fifo_cnt,
    output logic [15:0]        frame_cnt,
    output logic               ovf,
    output logic               len_err
);

    localparam int               DEPTH    = 1 << FIFO_AW;
    localparam logic [10:0]      PX_LAST  = 11'(WIDTH - 1);
    localparam logic [10:0]      LN_LAST  = 11'(HEIGHT - 1);
    localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t      state, state_n;
    logic [10:0] px, px_n, ln, ln_n;
    logic        first, first_n;

    // Position of the pixel seen this cycle; a sof_in in the same cycle
    // rebases it to pixel 0 of a new frame.
    logic [10:0] cur_px, cur_ln;
    logic        cur_first, in_frame;

    logic        wr_req, wr_user, wr_last;
    logic        frame_done, restart_err;

    always_comb begin
        state_n     = state;
        px_n        = px;
        ln_n        = ln;
        first_n     = first;
        wr_req      = 1'b0;
        wr_user     = 1'b0;
        wr_last     = 1'b0;
        frame_done  = 1'b0;
        restart_err = 1'b0;
        cur_px      = px;
        cur_ln      = ln;
        cur_first   = first;
        in_frame    = (state == ACTIVE);

        if (sof_in) begin
            restart_err = (state == ACTIVE);
            state_n     = ACTIVE;
            cur_px      = 11'd0;
            cur_ln      = 11'd0;
            cur_first   = 1'b1;
            in_frame    = 1'b1;
            px_n        = 11'd0;
            ln_n        = 11'd0;
            first_n     = 1'b1;
        end

        if (in_frame && v_in) begin
            wr_req  = 1'b1;
            wr_user = cur_first;
            wr_last = (cur_px == PX_LAST);
            first_n = 1'b0;
            if (cur_px == PX_LAST) begin
                px_n = 11'd0;
                if (cur_ln == LN_LAST) begin
                    ln_n       = 11'd0;
                    state_n    = IDLE;
                    frame_done = 1'b1;
                end else begin
                    ln_n = cur_ln + 11'd1;
                end
            end else begin
                px_n = cur_px + 11'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            px    <= 11'd0;
            ln    <= 11'd0;
            first <= 1'b0;
        end else if (!enb) begin
            state <= IDLE;
            px    <= 11'd0;
            ln    <= 11'd0;
            first <= 1'b0;
        end else begin
            state <= state_n;
            px    <= px_n;
            ln    <= ln_n;
            first <= first_n;
        end
    end

    // FIFO: memory holds every queued word including the one on the output
    // register, so fifo_cnt==DEPTH is the true capacity. The output register
    // is refreshed each edge from the head that will remain after this edge's
    // pop; a word written this edge becomes visible one edge later.
    logic [33:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr, head_n;
    logic [FIFO_AW:0]   cnt, remain;
    logic [33:0]        out_word;
    logic               out_valid;
    logic               full, rd_en, wr_en;

    assign full   = (cnt == CNT_FULL);
    assign rd_en  = out_valid & m_axis_tready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en  = wr_req & (~full | rd_en);
    assign head_n = rd_ptr + FIFO_AW'(rd_en);
    assign remain = cnt - (FIFO_AW + 1)'(rd_en);

    always_ff @(posedge clk) begin
        if (enb && wr_en) begin
            mem[wr_ptr] <= {wr_user, wr_last, d2_in, d1_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            len_err   <= 1'b0;
            frame_cnt <= 16'd0;
        end else if (!enb) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= head_n;
            unique case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (remain != '0) begin
                out_valid <= 1'b1;
                out_word  <= mem[head_n];
            end else begin
                out_valid <= 1'b0;
            end
            if (wr_req && full && !rd_en) begin
                ovf <= 1'b1;
            end
            if (restart_err) begin
                len_err <= 1'b1;
            end
            if (frame_done) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    assign m_axis_tvalid = out_valid;
    assign m_axis_tuser  = out_word[33];
    assign m_axis_tlast  = out_word[32];
    assign m_axis_tdata  = out_word[31:0];
    assign fifo_cnt      = cnt;

endmodule

// File: tb/tb_csi_axis_out.sv
// tb/tb_csi_axis_out.sv - directed table-driven bench for csi_axis_out (WIDTH=4, HEIGHT=2, FIFO_AW=2)
module tb_csi_axis_out;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enb;
    logic        sof_in;
    logic        v_in;
    logic [15:0] d1_in;
    logic [15:0] d2_in;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic [2:0]  fifo_cnt;
    logic [15:0] frame_cnt;
    logic        ovf;
    logic        len_err;

    csi_axis_out #(.WIDTH(4), .HEIGHT(2), .FIFO_AW(2)) dut (
        .clk(clk), .rst_n(rst_n), .enb(enb), .sof_in(sof_in), .v_in(v_in),
        .d1_in(d1_in), .d2_in(d2_in),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast), .fifo_cnt(fifo_cnt), .frame_cnt(frame_cnt),
        .ovf(ovf), .len_err(len_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic        sof;
        logic        v;
        logic [15:0] p;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_user;
        logic        e_last;
        int          e_cnt;
        int          e_fc;
    } vec_t;

    function automatic logic [31:0] w(input logic [15:0] p);
        return {16'h0100 + p, p};
    endfunction

    function automatic logic [33:0] bw(input logic [15:0] p, input logic u, input logic l);
        return {u, l, w(p)};
    endfunction

    function automatic vec_t mk(input logic sof, input logic v, input logic [15:0] p,
                                input logic ev, input logic [15:0] ep, input logic eu,
                                input logic el, input int ec, input int efc);
        vec_t r;
        r.sof = sof; r.v = v; r.p = p;
        r.e_valid = ev; r.e_data = w(ep); r.e_user = eu; r.e_last = el;
        r.e_cnt = ec; r.e_fc = efc;
        return r;
    endfunction

    // Beats that transfer at the next rising edge, captured mid-cycle.
    logic [33:0] beats [$];
    logic [33:0] exp_q [$];
    logic        stab_en = 1'b0;
    logic        prev_v  = 1'b0;
    logic        prev_r  = 1'b0;
    logic [31:0] prev_d  = '0;

    always @(negedge clk) begin
        if (rst_n && m_axis_tvalid && m_axis_tready)
            beats.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
        if (stab_en) begin
            if (prev_v && !prev_r) begin
                chk("stall_tvalid_held", m_axis_tvalid, 1'b1);
                chk("stall_tdata_held", m_axis_tdata, prev_d);
            end
            prev_v = m_axis_tvalid;
            prev_r = m_axis_tready;
            prev_d = m_axis_tdata;
        end else begin
            prev_v = 1'b0;
            prev_r = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic v, input logic [15:0] p);
        sof_in = s;
        v_in   = v;
        d1_in  = p;
        d2_in  = 16'h0100 + p;
    endtask

    task automatic compare_beats(input string name);
        chk({name, "_beat_count"}, beats.size(), exp_q.size());
        for (int i = 0; i < beats.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_beat%0d", name, i), beats[i], exp_q[i]);
    endtask

    task automatic flush();
        enb = 1'b0;
        tick();
        enb = 1'b1;
    endtask

    vec_t tbl [11];

    initial begin
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl[2]  = mk(0, 1, 1, 1, 0, 1, 0, 2, 0);
        tbl[3]  = mk(0, 1, 2, 1, 1, 0, 0, 2, 0);
        tbl[4]  = mk(0, 1, 3, 1, 2, 0, 0, 2, 0);
        tbl[5]  = mk(0, 1, 4, 1, 3, 0, 1, 2, 0);
        tbl[6]  = mk(0, 1, 5, 1, 4, 0, 0, 2, 0);
        tbl[7]  = mk(0, 1, 6, 1, 5, 0, 0, 2, 0);
        tbl[8]  = mk(0, 1, 7, 1, 6, 0, 0, 2, 1);
        tbl[9]  = mk(0, 0, 0, 1, 7, 0, 1, 1, 1);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);

        rst_n = 1'b0;
        enb = 1'b1;
        m_axis_tready = 1'b0;
        drive(0, 0, 0);
        tick();
        tick();
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tuser", m_axis_tuser, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_fifo_cnt", fifo_cnt, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_len_err", len_err, 0);
        rst_n = 1'b1;
        m_axis_tready = 1'b1;

        // v_in with no preceding sof is ignored
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 16'h00A0 + 16'(i));
            tick();
            chk("nosof_tvalid", m_axis_tvalid, 0);
            chk("nosof_fifo_cnt", fifo_cnt, 0);
        end

        // Full frame, tready=1, cycle-exact table
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].sof, tbl[i].v, tbl[i].p);
            tick();
            chk($sformatf("tbl%0d_tvalid", i), m_axis_tvalid, tbl[i].e_valid);
            chk($sformatf("tbl%0d_fifo_cnt", i), fifo_cnt, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_frame_cnt", i), frame_cnt, tbl[i].e_fc);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_tdata", i), m_axis_tdata, tbl[i].e_data);
                chk($sformatf("tbl%0d_tuser", i), m_axis_tuser, tbl[i].e_user);
                chk($sformatf("tbl%0d_tlast", i), m_axis_tlast, tbl[i].e_last);
            end
        end

        // FSM returned to IDLE: further v_in is ignored
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 16'h00B0);
            tick();
            chk("idle_after_frame_tvalid", m_axis_tvalid, 0);
            chk("idle_after_frame_fifo_cnt", fifo_cnt, 0);
        end

        // Overflow with tready=0
        m_axis_tready = 1'b0;
        drive(1, 0, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 16'h0010 + 16'(i));
            tick();
            if (i == 3) begin
                chk("ovf_cnt_at_full", fifo_cnt, 4);
                chk("ovf_not_yet", ovf, 0);
            end
            if (i == 4) chk("ovf_set_after_drop", ovf, 1);
        end
        drive(0, 0, 0);
        tick();
        chk("ovf_cnt_saturated", fifo_cnt, 4);
        chk("ovf_sticky", ovf, 1);
        chk("ovf_head_tvalid", m_axis_tvalid, 1);
        chk("ovf_head_tdata", m_axis_tdata, w(16'h0010));
        chk("ovf_head_tuser", m_axis_tuser, 1);
        chk("ovf_frame_cnt", frame_cnt, 2);
        beats.delete();
        exp_q = '{bw(16'h10, 1, 0), bw(16'h11, 0, 0), bw(16'h12, 0, 0), bw(16'h13, 0, 1)};
        m_axis_tready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        compare_beats("ovf_drain");
        chk("ovf_drain_cnt", fifo_cnt, 0);
        flush();
        tick();
        chk("ovf_cleared_by_enb", ovf, 0);

        // Mid-frame sof: len_err and restart
        beats.delete();
        drive(1, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 16'h0020 + 16'(i));
            tick();
        end
        chk("lenerr_before", len_err, 0);
        for (int i = 0; i < 8; i++) begin
            drive(i == 0, 1, 16'h0030 + 16'(i));
            tick();
            if (i == 0) chk("lenerr_set", len_err, 1);
            if (i == 4) chk("lenerr_fc_not_early", frame_cnt, 2);
            if (i == 7) chk("lenerr_fc_after_restart", frame_cnt, 3);
        end
        drive(0, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        exp_q = '{bw(16'h20, 1, 0), bw(16'h21, 0, 0), bw(16'h22, 0, 0),
                  bw(16'h30, 1, 0), bw(16'h31, 0, 0), bw(16'h32, 0, 0), bw(16'h33, 0, 1),
                  bw(16'h34, 0, 0), bw(16'h35, 0, 0), bw(16'h36, 0, 0), bw(16'h37, 0, 1)};
        compare_beats("lenerr");
        flush();
        tick();
        chk("lenerr_cleared_by_enb", len_err, 0);

        // tready toggling 1010..., pixels on odd cycles so every beat stalls once
        beats.delete();
        stab_en = 1'b1;
        begin
            int k;
            k = 0;
            for (int c = 0; c < 30; c++) begin
                m_axis_tready = (c % 2 == 0);
                if (c == 0) drive(1, 0, 0);
                else if ((c % 2 == 1) && k < 8) begin
                    drive(0, 1, 16'h0040 + 16'(k));
                    k++;
                end else drive(0, 0, 0);
                tick();
            end
        end
        stab_en = 1'b0;
        m_axis_tready = 1'b1;
        exp_q = '{bw(16'h40, 1, 0), bw(16'h41, 0, 0), bw(16'h42, 0, 0), bw(16'h43, 0, 1),
                  bw(16'h44, 0, 0), bw(16'h45, 0, 0), bw(16'h46, 0, 0), bw(16'h47, 0, 1)};
        compare_beats("toggle");
        chk("toggle_no_ovf", ovf, 0);
        chk("toggle_frame_cnt", frame_cnt, 4);

        // enb dropped with 3 words queued
        m_axis_tready = 1'b0;
        drive(1, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 16'h0050 + 16'(i));
            tick();
        end
        drive(1, 0, 0);
        tick();
        drive(0, 0, 0);
        tick();
        chk("enb_pre_cnt", fifo_cnt, 3);
        chk("enb_pre_len_err", len_err, 1);
        flush();
        chk("enb_flush_tvalid", m_axis_tvalid, 0);
        chk("enb_flush_cnt", fifo_cnt, 0);
        chk("enb_flush_len_err", len_err, 0);
        chk("enb_flush_ovf", ovf, 0);
        chk("enb_flush_frame_cnt", frame_cnt, 4);
        beats.delete();
        m_axis_tready = 1'b1;
        drive(1, 0, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 16'h0060 + 16'(i));
            tick();
        end
        drive(0, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        exp_q = '{bw(16'h60, 1, 0), bw(16'h61, 0, 0), bw(16'h62, 0, 0), bw(16'h63, 0, 1),
                  bw(16'h64, 0, 0), bw(16'h65, 0, 0), bw(16'h66, 0, 0), bw(16'h67, 0, 1)};
        compare_beats("after_enb");
        chk("after_enb_frame_cnt", frame_cnt, 5);

        // Asynchronous reset mid-frame with a word presented
        m_axis_tready = 1'b0;
        drive(1, 0, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 16'h0070 + 16'(i));
            tick();
        end
        drive(0, 0, 0);
        chk("arst_pre_tvalid", m_axis_tvalid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", m_axis_tvalid, 0);
        chk("arst_tdata", m_axis_tdata, 0);
        chk("arst_cnt", fifo_cnt, 0);
        chk("arst_frame_cnt", frame_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
